mem_sequencer: RTL and testbench

Multi-cycle SRAM access sequencer that sits directly downstream of the LC-3 control unit's `Mem_OE`/`Mem_WE` outputs and upstream of the MDR and the physical 16-bit SRAM. It turns level-held read/write requests into correctly timed SRAM strobes with programmable wait states. It captures read data into a holding register and reports completion with a one-cycle `Mem_Ready` pulse. The control unit's fixed-length memory states are sized against the latencies defined here.

---
 rtl/mem_sequencer.sv | 155 +++++++++++++++
 tb/tb_mem_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// SRAM access sequencer for the LC-3 datapath: level-held Mem_OE/Mem_WE in, timed SRAM strobes out.
// Optional feature: define MEM_IO_MAP_EN to map address 16'hFFFF to Switches/HEX_data.
module mem_sequencer #(
   parameter int unsigned READ_WAIT  = 2,
   parameter int unsigned WRITE_WAIT = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Mem_OE,
   input  logic        Mem_WE,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR_out,
   output logic [15:0] Mem_Rdata,
   output logic        Mem_Ready,
   output logic [19:0] SRAM_ADDR,
   input  logic [15:0] SRAM_DQ_in,
   output logic [15:0] SRAM_DQ_out,
   output logic        SRAM_DQ_oe,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   input  logic [15:0] Switches,
   output logic [15:0] HEX_data
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

   typedef enum logic [2:0] {
      IDLE, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              io_sel;
   logic              accept_c;
   logic              io_hit_c;
   logic              io_nxt_c;
   logic              rd_nxt_c;
   logic              wr_nxt_c;
   logic              sram_rd_c;
   logic              sram_wr_c;
   logic [DATA_W-1:0] rd_src_c;

   // State register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and wait-state counter; write wins when both requests are high
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (Mem_WE) begin
               state_nxt = WR_SETUP;
            end else if (Mem_OE) begin
               state_nxt = RD_WAIT;
               cnt_nxt   = RD_LOAD;
            end
         end
         RD_WAIT: begin
            if (cnt == '0) state_nxt = RD_CAP;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         RD_CAP:   state_nxt = DONE;
         WR_SETUP: begin
            state_nxt = WR_PULSE;
            cnt_nxt   = WR_LOAD;
         end
         WR_PULSE: begin
            if (cnt == '0) state_nxt = WR_HOLD;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         WR_HOLD:  state_nxt = DONE;
         DONE: begin
            if (!Mem_OE && !Mem_WE) state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they come straight off flops
   always_comb begin
      accept_c  = (state == IDLE) && (Mem_OE || Mem_WE);
      io_nxt_c  = accept_c ? io_hit_c : io_sel;
      rd_nxt_c  = (state_nxt == RD_WAIT) || (state_nxt == RD_CAP);
      wr_nxt_c  = (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) || (state_nxt == WR_HOLD);
      sram_rd_c = rd_nxt_c && !io_nxt_c;
      sram_wr_c = wr_nxt_c && !io_nxt_c;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         io_sel      <= 1'b0;
         SRAM_ADDR   <= '0;
         SRAM_DQ_out <= '0;
         SRAM_DQ_oe  <= 1'b0;
         Mem_Rdata   <= '0;
         Mem_Ready   <= 1'b0;
         SRAM_CE_N   <= 1'b1;
         SRAM_OE_N   <= 1'b1;
         SRAM_WE_N   <= 1'b1;
         SRAM_UB_N   <= 1'b1;
         SRAM_LB_N   <= 1'b1;
      end else begin
         if (accept_c) begin
            io_sel    <= io_hit_c;
            SRAM_ADDR <= ADDR_W'(MAR);
         end
         if (accept_c && Mem_WE) SRAM_DQ_out <= MDR_out;
         if (state_nxt == RD_CAP) Mem_Rdata <= rd_src_c;
         Mem_Ready  <= (state_nxt == RD_CAP) || (state_nxt == WR_HOLD);
         SRAM_DQ_oe <= sram_wr_c;
         SRAM_CE_N  <= !(sram_rd_c || sram_wr_c);
         SRAM_OE_N  <= !sram_rd_c;
         SRAM_WE_N  <= !((state_nxt == WR_PULSE) && !io_nxt_c);
         SRAM_UB_N  <= !(sram_rd_c || sram_wr_c);
         SRAM_LB_N  <= !(sram_rd_c || sram_wr_c);
      end
   end

`ifdef MEM_IO_MAP_EN
   assign io_hit_c = (MAR == 16'hFFFF);
   assign rd_src_c = io_sel ? Switches : SRAM_DQ_in;

   // Display register loads from the latched write data as the hold cycle begins
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         HEX_data <= '0;
      end else if ((state_nxt == WR_HOLD) && io_sel) begin
         HEX_data <= SRAM_DQ_out;
      end
   end
`else
   logic unused_switches;
   assign io_hit_c        = 1'b0;
   assign rd_src_c        = SRAM_DQ_in;
   assign unused_switches = ^Switches;
   assign HEX_data        = '0;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: cycle-offset reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_sequencer;

   localparam int unsigned RW     = 2;
   localparam int unsigned WW     = 2;
   localparam int          RD_LEN = RW + 1;
   localparam int          WR_LEN = WW + 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Mem_OE, Mem_WE;
   logic [15:0] MAR, MDR_out;
   logic [15:0] Mem_Rdata;
   logic        Mem_Ready;
   logic [19:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_in, SRAM_DQ_out;
   logic        SRAM_DQ_oe;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
   logic [15:0] Switches;
   logic [15:0] HEX_data;

   mem_sequencer #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
      .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .MAR(MAR), .MDR_out(MDR_out), .Mem_Rdata(Mem_Rdata), .Mem_Ready(Mem_Ready),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out),
      .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
      .Switches(Switches), .HEX_data(HEX_data)
   );

   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM device: drives data only while selected for read, writes while WE_N is low
   logic [15:0] sram_mem [0:65535];
   logic [15:0] ref_mem  [0:65535];
   assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? sram_mem[SRAM_ADDR[15:0]] : 16'hDEAD;
   always @(posedge Clk)
      if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe) sram_mem[SRAM_ADDR[15:0]] = SRAM_DQ_out;

   function automatic bit io_addr(input logic [15:0] a);
`ifdef MEM_IO_MAP_EN
      return a == 16'hFFFF;
`else
      return 1'b0;
`endif
   endfunction

   // Reference model: one access in flight, tracked by its cycle offset from acceptance
   bit          m_busy, m_wait, m_rd, m_io;
   int          m_k;
   logic [15:0] m_addr, m_data;
   logic [15:0] exp_rdata, exp_hex, exp_dq;
   logic [19:0] exp_addr;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_busy = 0; m_wait = 0; m_rd = 0; m_io = 0; m_k = 0;
         exp_rdata = '0; exp_hex = '0; exp_dq = '0; exp_addr = '0;
      end else if (m_busy) begin
         if (m_k == (m_rd ? RD_LEN : WR_LEN)) begin
            m_busy = 0;
            m_wait = 1;
         end else begin
            m_k++;
            if (m_rd && m_k == RD_LEN) exp_rdata = m_io ? Switches : ref_mem[m_addr];
            if (!m_rd && m_k == WR_LEN) begin
               if (m_io) exp_hex = m_data;
               else      ref_mem[m_addr] = m_data;
            end
         end
      end else if (m_wait) begin
         if (!Mem_OE && !Mem_WE) m_wait = 0;
      end else if (Mem_OE || Mem_WE) begin
         m_busy   = 1;
         m_k      = 1;
         m_rd     = !Mem_WE;
         m_addr   = MAR;
         m_io     = io_addr(MAR);
         exp_addr = {4'h0, MAR};
         if (Mem_WE) begin
            m_data = MDR_out;
            exp_dq = MDR_out;
         end
      end
   end

   // Per-cycle compare and event counters, sampled mid-cycle
   bit chk_en = 0;
   int cyc = 0, base = 0, first_ready = -1;
   int n_ready, n_oe, n_we, n_dqoe, n_ce;

   always @(negedge Clk) begin
      bit rd, wr, sr;
      cyc++;
      if (!SRAM_OE_N) n_oe++;
      if (!SRAM_WE_N) n_we++;
      if (SRAM_DQ_oe) n_dqoe++;
      if (!SRAM_CE_N) n_ce++;
      if (Mem_Ready === 1'b1) begin
         n_ready++;
         if (first_ready < 0) first_ready = cyc;
      end
      if (chk_en) begin
         rd = m_busy && m_rd;
         wr = m_busy && !m_rd;
         sr = !m_io;
         chk("ce_n",  32'(SRAM_CE_N),  32'(!((rd || wr) && sr)));
         chk("ub_n",  32'(SRAM_UB_N),  32'(!((rd || wr) && sr)));
         chk("lb_n",  32'(SRAM_LB_N),  32'(!((rd || wr) && sr)));
         chk("oe_n",  32'(SRAM_OE_N),  32'(!(rd && sr)));
         chk("we_n",  32'(SRAM_WE_N),  32'(!(wr && sr && m_k >= 2 && m_k <= WW + 1)));
         chk("dq_oe", 32'(SRAM_DQ_oe), 32'(wr && sr));
         chk("ready", 32'(Mem_Ready),  32'(m_busy && m_k == (m_rd ? RD_LEN : WR_LEN)));
         chk("rdata", 32'(Mem_Rdata),  32'(exp_rdata));
         chk("addr",  32'(SRAM_ADDR),  32'(exp_addr));
         chk("dq_out",32'(SRAM_DQ_out),32'(exp_dq));
         chk("hex",   32'(HEX_data),   32'(exp_hex));
      end
   end

   task automatic run_req(input logic oe, input logic we, input logic [15:0] a,
                          input logic [15:0] d, input int hold, input int tail);
      Mem_OE = oe; Mem_WE = we; MAR = a; MDR_out = d;
      base = cyc; first_ready = -1;
      n_ready = 0; n_oe = 0; n_we = 0; n_dqoe = 0; n_ce = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge Clk); #2;
         MAR = 16'($urandom); MDR_out = 16'($urandom);
      end
      Mem_OE = 0; Mem_WE = 0;
      for (int i = 0; i < tail; i++) begin
         @(posedge Clk); #2;
      end
   endtask

   int          op, sel;
   logic [15:0] a, v;

   initial begin
      Reset = 0; Mem_OE = 0; Mem_WE = 0; MAR = '0; MDR_out = '0; Switches = '0;
      for (int i = 0; i < 65536; i++) begin
         v = 16'($urandom);
         sram_mem[i] = v;
         ref_mem[i]  = v;
      end
      sram_mem[16'h3000] = 16'h1234;
      ref_mem[16'h3000]  = 16'h1234;
      @(posedge Clk); #2;
      chk_en = 1;
      repeat (2) begin @(posedge Clk); #2; end
      chk("rst_ce_n",  32'(SRAM_CE_N), 32'd1);
      chk("rst_ready", 32'(Mem_Ready), 32'd0);
      chk("rst_rdata", 32'(Mem_Rdata), 32'd0);
      Reset = 1;
      @(posedge Clk); #2;

      // Single read of x3000
      run_req(1, 0, 16'h3000, 16'h0, 4, 4);
      chk("rd_ready_cycle", 32'(first_ready - base - 1), 32'd3);
      chk("rd_data",        32'(Mem_Rdata), 32'h1234);
      chk("rd_oe_cycles",   32'(n_oe), 32'd3);
      chk("rd_pulses",      32'(n_ready), 32'd1);

      // Write then read back
      run_req(0, 1, 16'h0040, 16'hBEEF, 5, 4);
      chk("wr_ready_cycle", 32'(first_ready - base - 1), 32'd4);
      chk("wr_we_cycles",   32'(n_we), 32'd2);
      chk("wr_dqoe_cycles", 32'(n_dqoe), 32'd4);
      run_req(1, 0, 16'h0040, 16'h0, 4, 4);
      chk("readback", 32'(Mem_Rdata), 32'hBEEF);

      // Both requests high: write only
      run_req(1, 1, 16'h0050, 16'h1111, 5, 4);
      chk("both_oe_cycles", 32'(n_oe), 32'd0);
      chk("both_we_cycles", 32'(n_we), 32'd2);
      chk("both_pulses",    32'(n_ready), 32'd1);

      // Long-held read: exactly one access
      run_req(1, 0, 16'h3000, 16'h0, 20, 4);
      chk("long_pulses",    32'(n_ready), 32'd1);
      chk("long_oe_cycles", 32'(n_oe), 32'd3);

      // Reset in the middle of a read
      Mem_OE = 1; MAR = 16'h3000;
      @(posedge Clk); #2;
      @(posedge Clk); #3;
      Reset = 0;
      #1;
      chk("midrst_oe_n",  32'(SRAM_OE_N), 32'd1);
      chk("midrst_ce_n",  32'(SRAM_CE_N), 32'd1);
      chk("midrst_ready", 32'(Mem_Ready), 32'd0);
      Mem_OE = 0;
      @(posedge Clk); #2;
      Reset = 1;
      n_ready = 0;
      repeat (6) begin @(posedge Clk); #2; end
      chk("midrst_no_pulse", 32'(n_ready), 32'd0);

`ifdef MEM_IO_MAP_EN
      Switches = 16'h00A5;
      run_req(1, 0, 16'hFFFF, 16'h0, 4, 4);
      chk("io_rd_data", 32'(Mem_Rdata), 32'h00A5);
      chk("io_rd_ce",   32'(n_ce), 32'd0);
      run_req(0, 1, 16'hFFFF, 16'h0007, 5, 4);
      chk("io_wr_hex",  32'(HEX_data), 32'h0007);
      chk("io_wr_ce",   32'(n_ce), 32'd0);
`endif

      // Randomized traffic against the model
      for (int t = 0; t < 80; t++) begin
         sel = $urandom_range(0, 9);
         a   = (sel == 0) ? 16'hFFFF : 16'h0040 + 16'($urandom_range(0, 7));
         op  = $urandom_range(0, 3);
         Switches = 16'($urandom);
         run_req(op[0], op[1], a, 16'($urandom), $urandom_range(1, 10), $urandom_range(0, 3));
      end
      repeat (10) begin @(posedge Clk); #2; end
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
